// File: rtl/qsys_multi_interval_timer.sv
// rtl/qsys_multi_interval_timer.sv - N-channel Avalon-MM interval timer with shared prescaler and per-channel IRQs
module qsys_multi_interval_timer #(
    parameter int          NUM_CH    = 4,
    parameter int          COUNT_W   = 32,
    parameter int          PRESCALE  = 1,
    parameter int unsigned RESET_PER = 50000000,
    parameter int          ADDR_W    = $clog2(NUM_CH) + 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [NUM_CH-1:0] irq_vec,
    output logic              irq
);

    localparam logic [1:0] REG_STATUS  = 2'd0;
    localparam logic [1:0] REG_CONTROL = 2'd1;
    localparam logic [1:0] REG_PERIOD  = 2'd2;
    localparam logic [1:0] REG_SNAP    = 2'd3;

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [COUNT_W-1:0] RST_VAL = COUNT_W'(RESET_PER);

    // Shared prescaler; free-running, never disturbed by bus writes.
    logic [PS_W-1:0] pre_cnt;
    logic            tick;

    assign tick = (pre_cnt == PS_W'(PRESCALE - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    // Bus decode
    logic [ADDR_W-1:0] ch_sel;
    logic [1:0]        reg_sel;
    logic              wr_en;
    logic [NUM_CH-1:0] wr_status;
    logic [NUM_CH-1:0] wr_control;
    logic [NUM_CH-1:0] wr_period;
    logic [NUM_CH-1:0] wr_snap;

    assign ch_sel  = address >> 2;
    assign reg_sel = address[1:0];
    assign wr_en   = chipselect & ~write_n;

    always_comb begin
        wr_status  = '0;
        wr_control = '0;
        wr_period  = '0;
        wr_snap    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr_en && (ch_sel == ADDR_W'(i))) begin
                case (reg_sel)
                    REG_STATUS:  wr_status[i]  = 1'b1;
                    REG_CONTROL: wr_control[i] = 1'b1;
                    REG_PERIOD:  wr_period[i]  = 1'b1;
                    REG_SNAP:    wr_snap[i]    = 1'b1;
                    default:     ;
                endcase
            end
        end
    end

    // Channel state
    logic [COUNT_W-1:0] count_q  [NUM_CH];
    logic [COUNT_W-1:0] period_q [NUM_CH];
    logic [COUNT_W-1:0] snap_q   [NUM_CH];
    logic [NUM_CH-1:0]  run_q;
    logic [NUM_CH-1:0]  to_q;
    logic [NUM_CH-1:0]  ito_q;
    logic [NUM_CH-1:0]  cont_q;

    logic [NUM_CH-1:0]  step;
    logic [NUM_CH-1:0]  expire;
    logic [NUM_CH-1:0]  to_event;

    // A PERIOD write preempts counting for that cycle, so it also suppresses the timeout edge.
    // A zero period reloads zero, which still counts as arriving at zero on every tick.
    always_comb begin
        step     = '0;
        expire   = '0;
        to_event = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            step[i]     = tick && run_q[i] && !wr_period[i];
            expire[i]   = step[i] && (count_q[i] == '0);
            to_event[i] = step[i] && ((count_q[i] == COUNT_W'(1)) ||
                                      ((count_q[i] == '0) && (period_q[i] == '0)));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                count_q[i]  <= RST_VAL;
                period_q[i] <= RST_VAL;
                snap_q[i]   <= '0;
            end
            run_q  <= '0;
            to_q   <= '0;
            ito_q  <= '0;
            cont_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_period[i]) begin
                    period_q[i] <= writedata[COUNT_W-1:0];
                    count_q[i]  <= writedata[COUNT_W-1:0];
                end else if (expire[i]) begin
                    count_q[i]  <= period_q[i];
                end else if (step[i]) begin
                    count_q[i]  <= count_q[i] - COUNT_W'(1);
                end

                // Captures the register value, i.e. before any decrement on this edge.
                if (wr_snap[i]) begin
                    snap_q[i] <= count_q[i];
                end

                // A timeout landing on the same edge as a clear must not be lost.
                if (to_event[i]) begin
                    to_q[i] <= 1'b1;
                end else if (wr_status[i]) begin
                    to_q[i] <= 1'b0;
                end

                if (wr_control[i]) begin
                    ito_q[i]  <= writedata[0];
                    cont_q[i] <= writedata[1];
                end

                if (wr_period[i]) begin
                    run_q[i] <= 1'b0;
                end else if (wr_control[i] && writedata[2]) begin
                    run_q[i] <= 1'b1;
                end else if (wr_control[i] && writedata[3]) begin
                    run_q[i] <= 1'b0;
                end else if (expire[i] && !cont_q[i]) begin
                    run_q[i] <= 1'b0;
                end
            end
        end
    end

    // Read path: unmapped channels fall through to zero.
    logic [31:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == ADDR_W'(i)) begin
                case (reg_sel)
                    REG_STATUS:  rd_mux = {30'd0, run_q[i], to_q[i]};
                    REG_CONTROL: rd_mux = {30'd0, cont_q[i], ito_q[i]};
                    REG_PERIOD:  rd_mux[COUNT_W-1:0] = period_q[i];
                    REG_SNAP:    rd_mux[COUNT_W-1:0] = snap_q[i];
                    default:     rd_mux = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

    assign irq_vec = to_q & ito_q;
    assign irq     = |irq_vec;

    logic unused_wdata;
    assign unused_wdata = ^writedata;

endmodule

// File: tb/tb_qsys_multi_interval_timer.sv
// tb/tb_qsys_multi_interval_timer.sv - table and scoreboard bench for the multi-channel interval timer
`timescale 1ns/1ps
module tb_qsys_multi_interval_timer;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  address_a;
    logic        chipselect_a;
    logic        write_n_a;
    logic [31:0] writedata_a;
    logic [31:0] readdata_a;
    logic [3:0]  irq_vec_a;
    logic        irq_a;

    logic [4:0]  address_b;
    logic        chipselect_b;
    logic        write_n_b;
    logic [31:0] writedata_b;
    logic [31:0] readdata_b;
    logic [4:0]  irq_vec_b;
    logic        irq_b;

    qsys_multi_interval_timer dut_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address_a),
        .chipselect (chipselect_a),
        .write_n    (write_n_a),
        .writedata  (writedata_a),
        .readdata   (readdata_a),
        .irq_vec    (irq_vec_a),
        .irq        (irq_a)
    );

    qsys_multi_interval_timer #(.NUM_CH(5), .COUNT_W(16), .PRESCALE(4)) dut_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address_b),
        .chipselect (chipselect_b),
        .write_n    (write_n_b),
        .writedata  (writedata_b),
        .readdata   (readdata_b),
        .irq_vec    (irq_vec_b),
        .irq        (irq_b)
    );

    typedef struct {
        int          due;
        bit          dut;
        logic [31:0] exp;
        string       name;
    } sb_t;

    typedef struct {
        bit          is_wr;
        bit          dut;
        logic [7:0]  addr;
        logic [31:0] data;
    } vec_t;

    sb_t  sb[$];
    sb_t  mon_e;
    vec_t vtab [24];

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    int k, t0, t1, t2;
    bit ok;
    bit glitch;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic bus_write(input bit d, input logic [7:0] addr, input logic [31:0] data);
        @(negedge clk);
        if (d) begin
            address_b = addr[4:0]; writedata_b = data; chipselect_b = 1'b1; write_n_b = 1'b0;
        end else begin
            address_a = addr[3:0]; writedata_a = data; chipselect_a = 1'b1; write_n_a = 1'b0;
        end
        @(negedge clk);
        chipselect_a = 1'b0; write_n_a = 1'b1;
        chipselect_b = 1'b0; write_n_b = 1'b1;
    endtask

    task automatic bus_read(input bit d, input logic [7:0] addr, input logic [31:0] exp, input string name);
        sb_t e;
        @(negedge clk);
        if (d) address_b = addr[4:0];
        else   address_a = addr[3:0];
        e.due = cyc + 1; e.dut = d; e.exp = exp; e.name = name;
        sb.push_back(e);
    endtask

    task automatic wait_irq(input bit d, input int idx, input int budget, output int at, output bit found);
        found = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if ((d ? irq_vec_b[idx] : irq_vec_a[idx]) === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        at = cyc;
    endtask

    // Scoreboard: readdata is due one edge after the address was driven.
    always @(posedge clk) begin
        cyc++;
        #1;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            chk(mon_e.name, mon_e.dut ? readdata_b : readdata_a, mon_e.exp);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vtab[0]  = '{1'b1, 1'b0, 8'd2,  32'h1234_5678};
        vtab[1]  = '{1'b0, 1'b0, 8'd2,  32'h1234_5678};
        vtab[2]  = '{1'b1, 1'b0, 8'd1,  32'h0000_0003};
        vtab[3]  = '{1'b0, 1'b0, 8'd1,  32'h0000_0003};
        vtab[4]  = '{1'b0, 1'b0, 8'd0,  32'h0000_0000};
        vtab[5]  = '{1'b1, 1'b0, 8'd1,  32'h0000_000F};
        vtab[6]  = '{1'b0, 1'b0, 8'd0,  32'h0000_0002};
        vtab[7]  = '{1'b0, 1'b0, 8'd1,  32'h0000_0003};
        vtab[8]  = '{1'b1, 1'b0, 8'd1,  32'h0000_0008};
        vtab[9]  = '{1'b0, 1'b0, 8'd0,  32'h0000_0000};
        vtab[10] = '{1'b0, 1'b0, 8'd1,  32'h0000_0000};
        vtab[11] = '{1'b1, 1'b0, 8'd14, 32'hFFFF_FFFF};
        vtab[12] = '{1'b0, 1'b0, 8'd14, 32'hFFFF_FFFF};
        vtab[13] = '{1'b0, 1'b0, 8'd13, 32'h0000_0000};
        vtab[14] = '{1'b0, 1'b1, 8'd2,  32'h0000_F080};
        vtab[15] = '{1'b1, 1'b1, 8'd2,  32'hABCD_1234};
        vtab[16] = '{1'b0, 1'b1, 8'd2,  32'h0000_1234};
        vtab[17] = '{1'b1, 1'b1, 8'd22, 32'h0000_0055};
        vtab[18] = '{1'b0, 1'b1, 8'd22, 32'h0000_0000};
        vtab[19] = '{1'b0, 1'b1, 8'd18, 32'h0000_F080};
        vtab[20] = '{1'b1, 1'b1, 8'd29, 32'h0000_0004};
        vtab[21] = '{1'b0, 1'b1, 8'd28, 32'h0000_0000};
        vtab[22] = '{1'b0, 1'b1, 8'd3,  32'h0000_0000};
        vtab[23] = '{1'b0, 1'b1, 8'd0,  32'h0000_0000};

        address_a = '0; chipselect_a = 1'b0; write_n_a = 1'b1; writedata_a = '0;
        address_b = '0; chipselect_b = 1'b0; write_n_b = 1'b1; writedata_b = '0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_readdata_a", readdata_a, 32'h0);
        chk("rst_irq_a", 32'(irq_a), 32'h0);
        chk("rst_irq_vec_b", 32'(irq_vec_b), 32'h0);
        reset_n = 1'b1;
        bus_read(1'b0, 8'd2, 32'd50000000, "t1_ch0_period");
        bus_read(1'b0, 8'd0, 32'h0, "t1_ch0_status");
        bus_read(1'b0, 8'd1, 32'h0, "t1_ch0_control");
        bus_read(1'b0, 8'd3, 32'h0, "t1_ch0_snap");

        // Register map vectors
        for (int i = 0; i < 24; i++) begin
            if (vtab[i].is_wr) bus_write(vtab[i].dut, vtab[i].addr, vtab[i].data);
            else bus_read(vtab[i].dut, vtab[i].addr, vtab[i].data, $sformatf("vec%0d", i));
        end

        // Continuous ch1, PERIOD=9: timeouts every 10 clks
        bus_write(1'b0, 8'd6, 32'd9);
        bus_write(1'b0, 8'd5, 32'h7);
        k = cyc;
        wait_irq(1'b0, 1, 30, t0, ok);
        chk("t2_first_to", 32'(ok), 32'h1);
        chk("t2_first_latency", 32'(t0 - k), 32'd9);
        bus_write(1'b0, 8'd4, 32'h0);
        chk("t2_irq_cleared", 32'(irq_a), 32'h0);
        wait_irq(1'b0, 1, 30, t1, ok);
        chk("t2_interval", 32'(t1 - t0), 32'd10);

        // STATUS clear on the exact timeout edge loses to the event
        bus_write(1'b0, 8'd4, 32'h0);
        while (cyc < t1 + 8) @(negedge clk);
        bus_write(1'b0, 8'd4, 32'h0);
        chk("t5_to_kept", 32'(irq_vec_a[1]), 32'h1);
        bus_write(1'b0, 8'd4, 32'h0);
        chk("t5_irq_dropped", 32'(irq_a), 32'h0);
        bus_read(1'b0, 8'd4, 32'h2, "t2_run_stays");
        bus_write(1'b0, 8'd5, 32'h8);

        // One-shot ch2, PERIOD=4
        bus_write(1'b0, 8'd10, 32'd4);
        bus_write(1'b0, 8'd9, 32'h5);
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            chk($sformatf("t3_irq_c%0d", n), 32'(irq_vec_a[2]), (n >= 4) ? 32'h1 : 32'h0);
        end
        repeat (10) @(negedge clk);
        bus_read(1'b0, 8'd8, 32'h1, "t3_status");
        bus_write(1'b0, 8'd11, 32'h0);
        bus_read(1'b0, 8'd11, 32'd4, "t3_snap_hold");
        bus_write(1'b0, 8'd9, 32'h0);
        chk("t3_ito_masked", 32'(irq_vec_a[2]), 32'h0);
        bus_read(1'b0, 8'd8, 32'h1, "t3_to_kept");

        // PRESCALE=4, ch0 PERIOD=2 continuous: every 12 clks
        bus_write(1'b1, 8'd2, 32'd2);
        bus_write(1'b1, 8'd1, 32'h7);
        wait_irq(1'b1, 0, 40, t0, ok);
        chk("t4_first_to", 32'(ok), 32'h1);
        bus_write(1'b1, 8'd0, 32'h0);
        wait_irq(1'b1, 0, 40, t1, ok);
        chk("t4_interval1", 32'(t1 - t0), 32'd12);
        bus_write(1'b1, 8'd0, 32'h0);
        wait_irq(1'b1, 0, 40, t2, ok);
        chk("t4_interval2", 32'(t2 - t1), 32'd12);

        // ch3 PERIOD=1000: snap at 700, START+STOP keeps running without reload
        bus_write(1'b0, 8'd14, 32'd1000);
        bus_write(1'b0, 8'd13, 32'h4);
        k = cyc;
        while (cyc < k + 299) @(negedge clk);
        bus_write(1'b0, 8'd15, 32'h0);
        bus_read(1'b0, 8'd15, 32'd700, "t6_snap700");
        bus_write(1'b0, 8'd13, 32'hC);
        bus_write(1'b0, 8'd15, 32'h0);
        bus_read(1'b0, 8'd15, 32'd695, "t6_snap_no_reload");
        bus_read(1'b0, 8'd12, 32'h2, "t6_run_start_wins");

        // Asynchronous reset mid-count
        @(negedge clk);
        chk("pre_rst_irq_b", 32'(irq_b), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_async_irq_b", 32'(irq_b), 32'h0);
        chk("rst_async_readdata_a", readdata_a, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        glitch = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (irq_a !== 1'b0 || irq_b !== 1'b0) glitch = 1'b1;
        end
        chk("post_rst_no_irq", 32'(glitch), 32'h0);
        bus_read(1'b0, 8'd14, 32'd50000000, "post_rst_ch3_period");
        bus_read(1'b0, 8'd12, 32'h0, "post_rst_ch3_status");
        bus_read(1'b1, 8'd2, 32'h0000_F080, "post_rst_b_period");
        bus_read(1'b1, 8'd0, 32'h0, "post_rst_b_status");

        for (int n = 0; n < 5 && sb.size() > 0; n++) @(negedge clk);
        if (sb.size() != 0) chk("sb_drain", 32'(sb.size()), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
